// File: rtl/sram_arb_pkg.sv
// Shared definitions for the data-SRAM arbiter: FSM encoding, port IDs and default widths.
package sram_arb_pkg;

  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 16;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC_C = 2'd1,
    ST_ACC_L = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_L = 1'b1
  } port_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational eligibility and priority pick between the CPU (C) and loader (L) ports.
// A port is eligible when it requests, is not being acked, and does not already own the
// access in flight; L wins when C is ineligible or L has waited through STARVE_MAX C grants.
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             cpu_req,
  input  logic             cpu_ack,
  input  logic             cpu_busy,
  input  logic             ld_req,
  input  logic             ld_ack,
  input  logic             ld_busy,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             l_elig,
  output port_t            winner,
  output logic             valid
);

  logic c_elig;

  assign c_elig = cpu_req & ~cpu_ack & ~cpu_busy;
  assign l_elig = ld_req  & ~ld_ack  & ~ld_busy;
  assign valid  = c_elig | l_elig;

  // Priority: C by default, L when C cannot go or L has been starved long enough.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    winner = PORT_C;
    if (l_elig && (!c_elig || starve_cnt == CNT_W'(STARVE_MAX))) begin
      winner = PORT_L;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port data SRAM between the CPU MEM stage (C) and the loader (L).
// A grant registers the winner's command onto the SRAM pins; the access occupies one ACC
// cycle and the requester sees a one-cycle ack with read data in the following cycle.
// A write followed by a read inserts one TURN cycle with all strobes low so the bus can
// change direction.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_drive,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t             state, state_nx;
  port_t              winner, turn_port;
  logic               valid, l_elig, grant, in_acc, prev_wr, need_turn;
  logic               last_wr;
  logic [CNT_W-1:0]   starve_cnt;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  sram_arb_pick #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_pick (
    .cpu_req    (cpu_req),
    .cpu_ack    (cpu_ack),
    .cpu_busy   (state == ST_ACC_C),
    .ld_req     (ld_req),
    .ld_ack     (ld_ack),
    .ld_busy    (state == ST_ACC_L),
    .starve_cnt (starve_cnt),
    .l_elig     (l_elig),
    .winner     (winner),
    .valid      (valid)
  );

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign mem_drive = mem_we;

  assign win_we    = (winner == PORT_L) ? ld_we    : cpu_we;
  assign win_addr  = (winner == PORT_L) ? ld_addr  : cpu_addr;
  assign win_wdata = (winner == PORT_L) ? ld_wdata : cpu_wdata;

  // The direction of the bus right now: the live access in ACC, otherwise the last one made.
  assign in_acc    = (state == ST_ACC_C) || (state == ST_ACC_L);
  assign prev_wr   = in_acc ? mem_we : last_wr;
  assign need_turn = prev_wr & ~win_we;
  assign grant     = valid & (state != ST_TURN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state: TURN always proceeds to its pending access; otherwise arbitrate.
  always_comb begin
    state_nx = ST_IDLE;
    if (state == ST_TURN) begin
      state_nx = (turn_port == PORT_L) ? ST_ACC_L : ST_ACC_C;
    end else if (valid) begin
      if (need_turn)               state_nx = ST_TURN;
      else if (winner == PORT_L)   state_nx = ST_ACC_L;
      else                         state_nx = ST_ACC_C;
    end
  end

  // SRAM command registers: load the winner on a grant, release a held read after TURN.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: reset clears the strobes asynchronously, so an in-flight access is cut off
    // at once rather than at the next edge.
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      turn_port <= PORT_C;
    end else if (state == ST_TURN) begin
      mem_we <= 1'b0;
      mem_re <= 1'b1;
    end else if (valid) begin
      mem_addr  <= win_addr;
      mem_wdata <= win_wdata;
      mem_we    <= win_we;
      mem_re    <= ~win_we & ~need_turn;
      turn_port <= winner;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
    end
  end

  // Completion: each ACC cycle produces an ack and read data (zero for writes) next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack   <= 1'b0;
      ld_ack    <= 1'b0;
      cpu_rdata <= '0;
      ld_rdata  <= '0;
    end else begin
      cpu_ack <= (state == ST_ACC_C);
      ld_ack  <= (state == ST_ACC_L);
      if (state == ST_ACC_C) cpu_rdata <= mem_re ? mem_rdata : '0;
      if (state == ST_ACC_L) ld_rdata  <= mem_re ? mem_rdata : '0;
    end
  end

  // Bus-direction history and starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_wr    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (in_acc) last_wr <= mem_we;
      if (grant) begin
        if (winner == PORT_L)
          starve_cnt <= '0;
        else if (l_elig && starve_cnt < CNT_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and a per-cycle protocol monitor.
module tb_sram_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack, cpu_stall;
  logic          ld_req = 1'b0, ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_wdata = '0;
  logic [DW-1:0] ld_rdata;
  logic          ld_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_drive, mem_we, mem_re;
  logic [DW-1:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_drive(mem_drive),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  // Behavioural SRAM: fixed preload pattern until a location is written.
  logic [DW-1:0]  sram [0:(1<<AW)-1];
  logic [(1<<AW)-1:0] written = '0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      11'h010: init_val = 16'hBEEF;
      11'h030: init_val = 16'h1111;
      11'h031: init_val = 16'h2222;
      default: init_val = 16'h0000;
    endcase
  endfunction

  always_comb mem_rdata = written[mem_addr] ? sram[mem_addr] : init_val(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      sram[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  // Protocol monitor, sampled mid-low-phase after inputs driven at negedge have settled.
  logic prev_strobe = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      prev_strobe = 1'b0;
    end else begin
      n_cmp++;
      if ((mem_we & mem_re) !== 1'b0) begin
        n_err++; $display("FAIL mon_we_re_excl: we=%b re=%b required not both", mem_we, mem_re);
      end
      n_cmp++;
      if ((cpu_ack & ld_ack) !== 1'b0) begin
        n_err++; $display("FAIL mon_one_ack: cpu_ack=%b ld_ack=%b required at most one", cpu_ack, ld_ack);
      end
      n_cmp++;
      if ((cpu_ack | ld_ack) && !prev_strobe) begin
        n_err++; $display("FAIL mon_ack_grant: ack without preceding access cycle");
      end
      n_cmp++;
      if (cpu_stall !== (cpu_req & ~cpu_ack)) begin
        n_err++; $display("FAIL mon_stall: got %b required %b", cpu_stall, cpu_req & ~cpu_ack);
      end
      prev_strobe = mem_we | mem_re;
    end
  end

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_re, mem_drive, cpu_ack, ld_ack, cpu_stall} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b required 000000",
                        {mem_we, mem_re, mem_drive, cpu_ack, ld_ack, cpu_stall});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== '0) begin
      n_err++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h lrd=%h required all 0",
                        mem_addr, mem_wdata, cpu_rdata, ld_rdata);
    end
    rst = 1'b1;
  endtask

  task automatic test_c_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h010;
    #1;
    n_cmp++;
    if ({cpu_stall, mem_re} !== 2'b10) begin
      n_err++; $display("FAIL c_read_c0: stall,re=%b required 10", {cpu_stall, mem_re});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_re, mem_we, cpu_ack, cpu_stall, mem_addr} !== {4'b1001, 11'h010}) begin
      n_err++; $display("FAIL c_read_c1: re=%b we=%b ack=%b stall=%b addr=%h required 1,0,0,1,010",
                        mem_re, mem_we, cpu_ack, cpu_stall, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, cpu_stall, cpu_rdata} !== {2'b10, 16'hBEEF}) begin
      n_err++; $display("FAIL c_read_c2: ack=%b stall=%b rdata=%h required 1,0,BEEF",
                        cpu_ack, cpu_stall, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({cpu_ack, mem_re, mem_we} !== 3'b000) begin
      n_err++; $display("FAIL c_read_idle: ack,re,we=%b required 000", {cpu_ack, mem_re, mem_we});
    end
  endtask

  task automatic test_simultaneous();
    // Expected per cycle 1..6: access strobe and address, then acks and data.
    logic          exp_re   [1:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] exp_addr [1:6] = '{11'h030, 11'h031, 11'h000, 11'h030, 11'h031, 11'h000};
    logic          exp_cack [1:6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic          exp_lack [1:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h030;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 11'h031;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_re !== exp_re[c] || (exp_re[c] && mem_addr !== exp_addr[c])) begin
        n_err++; $display("FAIL simul_grant c%0d: re=%b addr=%h required re=%b addr=%h",
                          c, mem_re, mem_addr, exp_re[c], exp_addr[c]);
      end
      n_cmp++;
      if (cpu_ack !== exp_cack[c] || ld_ack !== exp_lack[c]) begin
        n_err++; $display("FAIL simul_ack c%0d: cack=%b lack=%b required %b %b",
                          c, cpu_ack, ld_ack, exp_cack[c], exp_lack[c]);
      end
      if (exp_cack[c]) begin
        n_cmp++;
        if (cpu_rdata !== 16'h1111) begin
          n_err++; $display("FAIL simul_crdata c%0d: got %h required 1111", c, cpu_rdata);
        end
      end
      if (exp_lack[c]) begin
        n_cmp++;
        if (ld_rdata !== 16'h2222) begin
          n_err++; $display("FAIL simul_lrdata c%0d: got %h required 2222", c, ld_rdata);
        end
      end
      // Both drop after cycle 5; L's latched read still completes in cycle 6.
      if (c == 5) begin cpu_req = 1'b0; ld_req = 1'b0; end
    end
  endtask

  task automatic test_starvation();
    int c_run = 0, c_run_max = 0, l_grants = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h040;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 11'h041;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_re | mem_we) begin
        if (mem_addr == 11'h040) begin
          c_run++;
          if (c_run > c_run_max) c_run_max = c_run;
        end else if (mem_addr == 11'h041) begin
          l_grants++;
          c_run = 0;
        end
      end
      cpu_req = ~cpu_ack;
    end
    n_cmp++;
    if (c_run_max > SMAX) begin
      n_err++; $display("FAIL starve_run: %0d consecutive C grants required <= %0d", c_run_max, SMAX);
    end
    n_cmp++;
    if (l_grants < 5) begin
      n_err++; $display("FAIL starve_lgrants: %0d L grants in 40 cycles required >= 5", l_grants);
    end
    cpu_req = 1'b0; ld_req = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({cpu_ack, ld_ack, mem_re, mem_we} !== 4'b0000) begin
      n_err++; $display("FAIL starve_drain: acks,re,we=%b required 0000", {cpu_ack, ld_ack, mem_re, mem_we});
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h005; cpu_wdata = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_drive, mem_re, mem_addr, mem_wdata} !== {3'b110, 11'h005, 16'h1234}) begin
      n_err++; $display("FAIL wr_acc: we=%b drv=%b re=%b addr=%h wdata=%h required 1,1,0,005,1234",
                        mem_we, mem_drive, mem_re, mem_addr, mem_wdata);
    end
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 11'h005;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_re, mem_drive} !== 3'b000) begin
      n_err++; $display("FAIL turn_strobes: we,re,drv=%b required 000", {mem_we, mem_re, mem_drive});
    end
    n_cmp++;
    if ({cpu_ack, cpu_rdata, ld_ack} !== {1'b1, 16'h0000, 1'b0}) begin
      n_err++; $display("FAIL wr_ack: cack=%b crdata=%h lack=%b required 1,0000,0",
                        cpu_ack, cpu_rdata, ld_ack);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_re, mem_we, mem_drive, ld_ack, mem_addr} !== {4'b1000, 11'h005}) begin
      n_err++; $display("FAIL rd_acc: re=%b we=%b drv=%b lack=%b addr=%h required 1,0,0,0,005",
                        mem_re, mem_we, mem_drive, ld_ack, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({ld_ack, ld_rdata, mem_drive} !== {1'b1, 16'h1234, 1'b0}) begin
      n_err++; $display("FAIL rd_ack: lack=%b lrdata=%h drv=%b required 1,1234,0",
                        ld_ack, ld_rdata, mem_drive);
    end
    ld_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_during_write();
    @(negedge clk);
    ld_req = 1'b1; ld_we = 1'b1; ld_addr = 11'h020; ld_wdata = 16'hAAAA;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr} !== {1'b1, 11'h020}) begin
      n_err++; $display("FAIL rstw_acc: we=%b addr=%h required 1,020", mem_we, mem_addr);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, mem_drive, ld_ack} !== 3'b000) begin
      n_err++; $display("FAIL rstw_abort: we,drv,lack=%b required 000", {mem_we, mem_drive, ld_ack});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({mem_we, ld_ack} !== 2'b00) begin
      n_err++; $display("FAIL rstw_held: we,lack=%b required 00", {mem_we, ld_ack});
    end
    @(negedge clk);
    n_cmp++;
    if (mem_rdata_at(11'h020) !== 16'h0000) begin
      n_err++; $display("FAIL rstw_nocommit: sram[020]=%h required 0000", mem_rdata_at(11'h020));
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 11'h020, 16'hAAAA}) begin
      n_err++; $display("FAIL rstw_reissue: we=%b addr=%h wdata=%h required 1,020,AAAA",
                        mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({ld_ack, ld_rdata} !== {1'b1, 16'h0000}) begin
      n_err++; $display("FAIL rstw_ack: lack=%b lrdata=%h required 1,0000", ld_ack, ld_rdata);
    end
    ld_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_rdata_at(11'h020) !== 16'hAAAA) begin
      n_err++; $display("FAIL rstw_commit: sram[020]=%h required AAAA", mem_rdata_at(11'h020));
    end
  endtask

  function automatic logic [DW-1:0] mem_rdata_at(input logic [AW-1:0] a);
    mem_rdata_at = written[a] ? sram[a] : init_val(a);
  endfunction

  initial begin
    test_reset();
    test_c_read();
    test_simultaneous();
    test_starvation();
    test_write_then_read();
    test_reset_during_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
